// File: rtl/midori64_ti_round_ctrl.sv
// ---------------------------------------------------------------------------
// midori64_ti_round_ctrl
//
// Round sequencer for the masked (threshold-implementation) Midori64 core.
// One encryption is a single plaintext-load cycle followed by NUM_ROUNDS
// rounds. Each round occupies STAGES cycles of the pipelined TI round
// function. The shared 64-bit state register lives in the datapath; this
// block only tells it when to load and when to capture.
//
// Parameters:
//   NUM_ROUNDS  rounds per encryption (2..16)
//   STAGES      cycles per round, equal to the TI S-box pipeline depth (>=1)
//
// Ports:
//   clk         system clock, everything updates on the rising edge
//   rst_n       synchronous active-low reset
//   start       request a new encryption (only looked at while idle)
//   in_ready    idle and willing to accept start
//   load_pt     state register takes plaintext ^ whitening key this cycle
//   state_en    state register takes the round-function output this cycle
//   round_idx   current round number, selects the round constant
//   key_sel     round-key half select (LSB of round_idx)
//   last_round  final round: datapath skips MixColumn/ShuffleCell and
//               applies the output whitening
//   rand_en     advance the fresh-mask PRNG
//   busy        loading or running rounds
//   out_valid   ciphertext shares are sitting in the state register
//   out_ready   consumer takes the ciphertext
//
// Every output is decoded from registered state only, so no input ever
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module midori64_ti_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int STAGES     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       in_ready,
    output logic       load_pt,
    output logic       state_en,
    output logic [3:0] round_idx,
    output logic       key_sel,
    output logic       last_round,
    output logic       rand_en,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    // A one-stage pipeline still needs a 1-bit counter so the width never
    // collapses to zero; with STAGES=1 that counter simply stays at 0.
    localparam int SCW = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [SCW-1:0] STAGE_LAST = SCW'(STAGES - 1);
    localparam logic [3:0]     ROUND_LAST = 4'(NUM_ROUNDS - 1);

    logic [1:0]     state;
    logic [3:0]     round_cnt;
    logic [SCW-1:0] stage_cnt;
    logic           stage_end;
    logic           round_end;

    // The round function output is ready on the final pipeline stage of a
    // round; that is also the only point where the round number may move.
    assign stage_end = (stage_cnt == STAGE_LAST);
    assign round_end = (round_cnt == ROUND_LAST);

    // Main sequencer. Reset wins over everything, including a round in
    // flight; the datapath contents are deliberately left alone. In ROUND the
    // stage counter free-runs and wraps on the last stage. On the wrap of the
    // final round the round counter is held at NUM_ROUNDS-1 rather than
    // incremented, so it cannot overflow for NUM_ROUNDS=16.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_cnt <= '0;
            stage_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    round_cnt <= '0;
                    stage_cnt <= '0;
                    state     <= ROUND;
                end
                ROUND: begin
                    if (stage_end) begin
                        stage_cnt <= '0;
                        if (round_end) begin
                            state <= DONE;
                        end else begin
                            round_cnt <= round_cnt + 4'd1;
                        end
                    end else begin
                        stage_cnt <= stage_cnt + SCW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode. round_idx is gated by state so that IDLE and LOAD
    // show 0 even though round_cnt still holds the last round from the
    // previous encryption. last_round and state_en are only meaningful inside
    // ROUND. DONE keeps presenting the final round number.
    always_comb begin
        in_ready   = 1'b0;
        load_pt    = 1'b0;
        state_en   = 1'b0;
        round_idx  = 4'd0;
        last_round = 1'b0;
        rand_en    = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            LOAD: begin
                load_pt = 1'b1;
                rand_en = 1'b1;
                busy    = 1'b1;
            end
            ROUND: begin
                busy       = 1'b1;
                rand_en    = 1'b1;
                round_idx  = round_cnt;
                state_en   = stage_end;
                last_round = round_end;
            end
            DONE: begin
                out_valid = 1'b1;
                round_idx = ROUND_LAST;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // The round key alternates halves with the round number.
    assign key_sel = round_idx[0];

endmodule

// File: doc/midori64_ti_round_ctrl.md
# midori64_ti_round_ctrl

Round controller for the masked (threshold-implementation) Midori64 core. It sequences the 64-bit shared state register: a one-cycle plaintext load, then NUM_ROUNDS rounds through the pipelined TI round function. Each round takes STAGES cycles. Per cycle it drives the state-register load and enable, the round index (for round constants), the round-key select, the last-round flag and the fresh-randomness enable. Software-facing start and result handshakes sit on either side.

## Interface
- NUM_ROUNDS, 16, rounds per encryption; legal range 2..16.
- STAGES, 3, cycles per round (TI S-box pipeline depth); legal range ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  in  1  request to begin an encryption; honoured only in IDLE.
- in_ready  out  1  high in IDLE: controller accepts start.
- load_pt  out  1  state register captures plaintext ⊕ whitening key this cycle.
- state_en  out  1  state register captures round-function output this cycle.
- round_idx  out  4  current round number, 0..NUM_ROUNDS-1; indexes round constant.
- key_sel  out  1  round-key half select, equal to round_idx[0].
- last_round  out  1  high while round_idx == NUM_ROUNDS-1; the datapath bypasses MixColumn/ShuffleCell and applies final whitening.
- rand_en  out  1  fresh-mask PRNG advance enable.
- busy  out  1  high in LOAD and ROUND.
- out_valid  out  1  ciphertext shares valid in state register.
- out_ready  in  1  consumer accepts ciphertext.

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE. Registers: state, round_cnt (4 bit), stage_cnt (width ceil(log2(STAGES)), min 1).
- All outputs are Moore decodes of registered state. There is no combinational path from input to output.
- IDLE: in_ready=1, all other outputs 0. If start=1, go to LOAD.
- LOAD (exactly 1 cycle): load_pt=1, rand_en=1, busy=1. Clear round_cnt and stage_cnt, then go to ROUND.
- ROUND: busy=1, rand_en=1, round_idx=round_cnt, key_sel=round_cnt[0].
  - stage_cnt increments each cycle.
  - When stage_cnt==STAGES-1: state_en=1 and stage_cnt wraps to 0.
  - At that point, if round_cnt==NUM_ROUNDS-1, go to DONE; otherwise round_cnt increments.
  - With STAGES=1, state_en is high every ROUND cycle.
- DONE: out_valid=1, round_idx holds NUM_ROUNDS-1, state_en=0. If out_ready=1, go to IDLE.
- load_pt and state_en are never high in the same cycle.
- start is ignored outside IDLE. It has no effect and is not queued.
- out_ready is ignored outside DONE.
- Reset: rst_n=0 at any edge, including mid-round, forces IDLE and clears round_cnt and stage_cnt. The next cycle shows reset outputs. The datapath contents are not cleared by this block.
- Reset values: in_ready=1 (IDLE decode); load_pt, state_en, round_idx, key_sel, last_round, rand_en, busy, out_valid all 0.

## Timing
- start sampled high in IDLE at edge t gives LOAD during cycle t+1. ROUND runs for cycles t+2 .. t+1+NUM_ROUNDS·STAGES.
- state_en pulses at cycles t+1+k·STAGES, for k=1..NUM_ROUNDS.
- out_valid rises at t+2+NUM_ROUNDS·STAGES. With defaults that is t+50, with 16 state_en pulses.
- out_valid holds until the edge at which out_ready=1. The next cycle is IDLE (in_ready=1).
- Minimum start-to-start spacing is NUM_ROUNDS·STAGES+3 cycles (out_ready tied high).
- last_round is high for exactly STAGES cycles per encryption, ending with the final state_en.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, release. Expect in_ready=1 and all other outputs 0; start=0 keeps IDLE indefinitely.
- Nominal run (defaults): pulse start at t. Expect load_pt only at t+1, state_en at t+4, t+7 … t+49 (16 pulses), round_idx stepping 0..15, key_sel alternating 0/1, last_round high t+47..t+49, and out_valid at t+50.
- Output backpressure: out_ready=0 for 10 cycles after out_valid. out_valid stays 1 and start pulses are ignored. Assert out_ready: IDLE next cycle, then a new start is accepted.
- Start while busy: pulse start at t+10 of a run. Pulse count and timing are identical to the nominal run, and no second LOAD occurs.
- Reset mid-operation: drop rst_n at t+20 for 1 cycle. Next cycle is IDLE with all counters 0, and a new start reproduces the nominal timing.
- Parameter corners: NUM_ROUNDS=2, STAGES=1. Expect state_en at t+2 and t+3, last_round only at t+3, out_valid at t+4.
